// File: rtl/vram_cmd_writer_pkg.sv
// Shared types for the VRAM command writer: op codes, FSM states, command word.
package vram_cmd_pkg;
  localparam int VRAM_ADDR_W = 4;
  localparam int VRAM_DATA_W = 6;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE1 = 2'd1,
    ST_SWEEP  = 2'd2
  } state_e;

  // Command word as stored in the FIFO; sized by the VRAM geometry above.
  typedef struct packed {
    op_e                    op;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
  } cmd_t;
endpackage

// File: rtl/vram_cmd_writer_if.sv
// Command handshake bus: producer drives CMD_*, writer returns CMD_READY.
interface vram_cmd_writer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 6
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_DATA;

  modport master (output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, output CMD_READY);
endinterface

// File: rtl/vram_cmd_writer_fifo.sv
// Small synchronous command FIFO; push ignored when full, pop ignored when empty.
module vram_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 12,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vram_cmd_writer.sv
// VRAM write front end: buffers WRITE/FILL/CLEAR commands and replays them as
// single-cycle RAM writes. Define VRAM_CMD_WRITER_WRCOUNT_EN to add WR_COUNT.
module vram_cmd_writer
  import vram_cmd_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  vram_cmd_writer_if.slave  cmd,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WEN,
  output logic              BUSY
`ifdef VRAM_CMD_WRITER_WRCOUNT_EN
  ,
  output logic [15:0]       WR_COUNT
`endif
);
  localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LAST    = {1'b0, {ADDR_W{1'b1}}};

  cmd_t              w_din, w_head;
  logic [CW-1:0]     w_count;
  logic              w_full, w_empty, w_push, w_pop, w_last;

  state_e            r_state;
  logic [ADDR_W:0]   r_idx;     // one spare bit so the last index never aliases 0
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;

  assign cmd.CMD_READY = (w_count < DEPTH_C);
  assign w_push = cmd.CMD_VALID && !w_full;
  assign w_din  = {cmd.CMD_OP, cmd.CMD_ADDR, cmd.CMD_DATA};
  assign w_last = (r_state == ST_SWEEP) && (r_idx == LAST);
  // Pop whenever idle or on the final cycle of a command, so writes chain without a bubble.
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_WRITE1) || w_last);

  vram_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Command FSM plus the RAM port registers, which present each state's write one cycle later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_wen   <= 1'b1;
        r_waddr <= (r_state == ST_SWEEP) ? r_idx[ADDR_W-1:0] : r_addr;
        r_wdata <= r_data;
      end else begin
        r_wen   <= 1'b0;
      end

      if (w_pop) begin
        r_idx  <= '0;
        r_addr <= w_head.addr;
        case (w_head.op)
          OP_WRITE: begin r_state <= ST_WRITE1; r_data <= w_head.data; end
          OP_FILL:  begin r_state <= ST_SWEEP;  r_data <= w_head.data; end
          OP_CLEAR: begin r_state <= ST_SWEEP;  r_data <= '0;          end
          default:  r_state <= ST_IDLE;   // reserved op is dropped
        endcase
      end else if ((r_state == ST_SWEEP) && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign RAM_WADDR = r_waddr;
  assign RAM_WDATA = r_wdata;
  assign RAM_WEN   = r_wen;
  // r_wen term keeps BUSY up through the trailing registered write cycle.
  assign BUSY      = !w_empty || (r_state != ST_IDLE) || r_wen;

`ifdef VRAM_CMD_WRITER_WRCOUNT_EN
  logic [15:0] r_wr_count;
  // Free-running count of write cycles, wrapping at 16 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     r_wr_count <= '0;
    else if (r_wen) r_wr_count <= r_wr_count + 1'b1;
  end
  assign WR_COUNT = r_wr_count;
`endif
endmodule

// File: tb/tb_vram_cmd_writer.sv
// Bench for vram_cmd_writer: directed scenarios plus a randomized command stream,
// checked against a queue of expected RAM writes built from the command semantics.
module tb_vram_cmd_writer;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] RAM_WADDR;
  logic [5:0] RAM_WDATA;
  logic       RAM_WEN, BUSY;
`ifdef VRAM_CMD_WRITER_WRCOUNT_EN
  logic [15:0] WR_COUNT;
`endif

  vram_cmd_writer_if #(.ADDR_W(4), .DATA_W(6)) bus ();

  vram_cmd_writer #(.ADDR_W(4), .DATA_W(6), .FIFO_DEPTH(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd       (bus),
    .RAM_WADDR (RAM_WADDR),
    .RAM_WDATA (RAM_WDATA),
    .RAM_WEN   (RAM_WEN),
    .BUSY      (BUSY)
`ifdef VRAM_CMD_WRITER_WRCOUNT_EN
    ,
    .WR_COUNT  (WR_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  acc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every write cycle seen on the RAM port, stamped with the edge that launched it.
  always @(negedge CLK) begin
    if (RAM_WEN === 1'b1) obs_q.push_back('{int'(RAM_WADDR), int'(RAM_WDATA), cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: what a command means in terms of RAM writes.
  task automatic model(input int op, input int a, input int d);
    case (op)
      0: exp_q.push_back('{a, d, 0});
      1: for (int i = 0; i < 16; i++) exp_q.push_back('{i, d, 0});
      2: for (int i = 0; i < 16; i++) exp_q.push_back('{i, 0, 0});
      default: ;
    endcase
  endtask

  task automatic send(input int op, input int a, input int d);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    bus.CMD_OP    = 2'(op);
    bus.CMD_ADDR  = 4'(a);
    bus.CMD_DATA  = 6'(d);
    bus.CMD_VALID = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (bus.CMD_READY === 1'b1) begin
        @(posedge CLK); #1;
        acc = cyc;
        ok  = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    bus.CMD_VALID = 1'b0;
    chk("accept", 32'(ok), 32'd1);
    if (ok) model(op, a, d);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 3000 && BUSY !== 1'b0; t++) @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("drain_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit found;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'd0;
    bus.CMD_ADDR  = 4'd0;
    bus.CMD_DATA  = 6'd0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_wen",   32'(RAM_WEN),   32'd0);
    chk("rst_waddr", 32'(RAM_WADDR), 32'd0);
    chk("rst_wdata", 32'(RAM_WDATA), 32'd0);
    chk("rst_busy",  32'(BUSY),      32'd0);
    chk("rst_ready", 32'(bus.CMD_READY), 32'd1);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single WRITE: latency and one pulse
    send(0, 5, 6'h2A);
    @(negedge CLK);
    chk("busy_after_accept", 32'(BUSY), 32'd1);
    wait_idle();
    if (obs_q.size() > 0) chk("write_latency", obs_q[0].cyc, acc + 2);
    compare("write1");

    // FILL then CLEAR
    send(1, 0, 6'h15);
    send(2, 0, 6'h3F);
    wait_idle();
    compare("fill_clear");

    // FILL then six WRITEs: FIFO fills, then everything streams without gaps
    send(1, 0, 6'h09);
    send(0, 3, 7);
    for (int i = 1; i < 4; i++) send(0, i + 8, i + 20);
    @(negedge CLK);
    chk("ready_full", 32'(bus.CMD_READY), 32'd0);
    send(0, 12, 30);
    send(0, 13, 31);
    wait_idle();
    chk("stream_len", obs_q.size(), 22);
    for (int i = 1; i < obs_q.size(); i++) chk("no_gap", obs_q[i].cyc, obs_q[0].cyc + i);
    compare("stream");

    // Reset pulse in the middle of a sweep
    send(1, 0, 6'h3C);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge CLK); #2;
      if (RAM_WEN === 1'b1 && RAM_WADDR == 4'd8) found = 1'b1;
    end
    chk("sweep_idx8_seen", 32'(found), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midrst_wen",   32'(RAM_WEN),   32'd0);
    chk("midrst_busy",  32'(BUSY),      32'd0);
    chk("midrst_ready", 32'(bus.CMD_READY), 32'd1);
    #3 RST_N = 1'b1;
    repeat (30) @(negedge CLK);
    chk("midrst_total", obs_q.size(), 8);
    exp_q.delete();
    for (int i = 0; i < 8; i++) model(0, i, 6'h3C);
    compare("midrst");

    // Reserved op is swallowed; only the WRITE lands
    send(3, 7, 6'h11);
    send(0, 1, 1);
    wait_idle();
    compare("rsvd");
`ifdef VRAM_CMD_WRITER_WRCOUNT_EN
    chk("wr_count", 32'(WR_COUNT), 32'd1);
`endif

    // Randomized command stream with random gaps
    for (int k = 0; k < 40; k++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_idle();
    compare("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
